// File: rtl/rr_gen_pkg.sv
// Shared types and slicing helpers for the weighted round-robin arbiter.
// Buses are zero-extended to BUS_MAX bits so one set of helpers serves every parameterisation.
package rr_gen_pkg;

    typedef enum logic {
        S_INIT  = 1'b0,
        S_SERVE = 1'b1
    } state_t;

    localparam int BUS_MAX = 1024;

    function automatic int weight_w(input int max_weight);
        return (max_weight > 1) ? $clog2(max_weight) : 1;
    endfunction

    function automatic int queue_w(input int queue_quantity);
        return (queue_quantity > 1) ? $clog2(queue_quantity) : 1;
    endfunction

    function automatic int slot_w(input int table_size);
        return (table_size > 1) ? $clog2(table_size) : 1;
    endfunction

    // Generic field extractor: field idx of a packed bus whose fields are width bits wide.
    function automatic logic [31:0] field_get(input logic [BUS_MAX-1:0] bus,
                                              input int idx,
                                              input int width);
        logic [31:0] mask;
        mask = (32'd1 << width) - 32'd1;
        return 32'(bus >> (idx * width)) & mask;
    endfunction

    function automatic logic [31:0] slot_weight(input logic [BUS_MAX-1:0] pesos,
                                                input int slot,
                                                input int ww);
        return field_get(pesos, slot, ww);
    endfunction

    function automatic logic [31:0] slot_queue(input logic [BUS_MAX-1:0] selecciones,
                                               input int slot,
                                               input int sw);
        return field_get(selecciones, slot, sw);
    endfunction

    function automatic logic [31:0] queue_count(input logic [BUS_MAX-1:0] fifo_counter,
                                                input int queue,
                                                input int bw);
        return field_get(fifo_counter, queue, bw);
    endfunction

endpackage

// File: rtl/round_robin_ponderado_gen_detector_umbral.sv
// Combinational lowest-index priority encoder over queues at or above the urgent threshold.
// Zero latency; empty queues never hit regardless of their counter.
module detector_umbral #(
    parameter int QUEUE_QUANTITY = 4,
    parameter int BUF_WIDTH      = 3,
    parameter int SW             = 2
) (
    input  logic                                enable,
    input  logic [QUEUE_QUANTITY-1:0]           buf_empty,
    input  logic [QUEUE_QUANTITY*BUF_WIDTH-1:0] fifo_counter,
    input  logic [BUF_WIDTH-1:0]                umbral_alto,
    output logic                                hit,
    output logic [SW-1:0]                       idx
);

    // Scan from the top down so the lowest qualifying queue is the last one written.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int q = QUEUE_QUANTITY - 1; q >= 0; q--) begin
            if (enable && !buf_empty[q] &&
                (fifo_counter[q*BUF_WIDTH +: BUF_WIDTH] >= umbral_alto)) begin
                hit = 1'b1;
                idx = SW'(q);
            end
        end
    end

endmodule

// File: rtl/round_robin_ponderado_gen.sv
// Table-driven weighted round-robin arbiter with urgent override; all outputs registered (1 cycle).
// dest_ready=0 or enb=0 freezes slot/credit/state and drops the pop strobe; selector holds.
module round_robin_ponderado_gen
    import rr_gen_pkg::*;
#(
    parameter int QUEUE_QUANTITY = 4,
    parameter int BUF_WIDTH      = 3,
    parameter int MAX_WEIGHT     = 64,
    parameter int TABLE_SIZE     = 8,
    localparam int WW            = weight_w(MAX_WEIGHT),
    localparam int SW            = queue_w(QUEUE_QUANTITY),
    localparam int TW            = slot_w(TABLE_SIZE)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                enb,
    input  logic                                dest_ready,
    input  logic [TABLE_SIZE*WW-1:0]            pesos,
    input  logic [TABLE_SIZE*SW-1:0]            selecciones,
    input  logic [QUEUE_QUANTITY-1:0]           buf_empty,
    input  logic [QUEUE_QUANTITY*BUF_WIDTH-1:0] fifo_counter,
    input  logic [BUF_WIDTH-1:0]                umbral_alto,
    input  logic                                modo_urgente,
    output logic [SW-1:0]                       selector,
    output logic                                selector_enb,
    output logic                                urgente,
    output logic [TW-1:0]                       slot_idx
);

    state_t         state_q, state_d;
    logic [TW-1:0]  slot_q, slot_d;
    logic [WW-1:0]  credito_q, credito_d;
    logic [SW-1:0]  selector_q, selector_d;
    logic           selector_enb_q, selector_enb_d;
    logic           urgente_q, urgente_d;

    logic [BUS_MAX-1:0] pesos_x;
    logic [BUS_MAX-1:0] selecciones_x;
    logic [BUS_MAX-1:0] counter_x;

    assign pesos_x       = BUS_MAX'(pesos);
    assign selecciones_x = BUS_MAX'(selecciones);
    assign counter_x     = BUS_MAX'(fifo_counter);

    logic                 urg_hit;
    logic [SW-1:0]        urg_idx;

    detector_umbral #(
        .QUEUE_QUANTITY (QUEUE_QUANTITY),
        .BUF_WIDTH      (BUF_WIDTH),
        .SW             (SW)
    ) u_detector_umbral (
        .enable       (modo_urgente),
        .buf_empty    (buf_empty),
        .fifo_counter (fifo_counter),
        .umbral_alto  (umbral_alto),
        .hit          (urg_hit),
        .idx          (urg_idx)
    );

    logic [SW-1:0]        cur_q;
    logic [BUF_WIDTH-1:0] cur_cnt;
    logic                 cur_empty;
    logic                 guard_blk;
    logic [TW-1:0]        slot_nxt;
    logic [WW-1:0]        weight_nxt;
    logic [WW-1:0]        weight_first;

    always_comb begin
        cur_q        = SW'(slot_queue(selecciones_x, int'(slot_q), SW));
        cur_cnt      = BUF_WIDTH'(queue_count(counter_x, int'(cur_q), BUF_WIDTH));
        cur_empty    = buf_empty[cur_q];
        // The counter may not yet reflect the pop issued last cycle, so a repeat
        // grant needs at least one word beyond the one already in flight.
        guard_blk    = selector_enb_q && (selector_q == cur_q) && (int'(cur_cnt) < 2);
        slot_nxt     = (int'(slot_q) == TABLE_SIZE - 1) ? '0 : slot_q + TW'(1);
        weight_nxt   = WW'(slot_weight(pesos_x, int'(slot_nxt), WW));
        weight_first = WW'(slot_weight(pesos_x, 0, WW));
    end

    always_comb begin
        state_d        = state_q;
        slot_d         = slot_q;
        credito_d      = credito_q;
        selector_d     = selector_q;
        selector_enb_d = 1'b0;
        urgente_d      = 1'b0;

        if (enb) begin
            case (state_q)
                S_INIT: begin
                    slot_d    = '0;
                    credito_d = weight_first;
                    state_d   = S_SERVE;
                end
                S_SERVE: begin
                    if (dest_ready) begin
                        if (urg_hit) begin
                            selector_d     = urg_idx;
                            selector_enb_d = 1'b1;
                            urgente_d      = 1'b1;
                        end else if ((credito_q == '0) || cur_empty) begin
                            slot_d    = slot_nxt;
                            credito_d = weight_nxt;
                        end else if (!guard_blk) begin
                            selector_d     = cur_q;
                            selector_enb_d = 1'b1;
                            if (credito_q == WW'(1)) begin
                                slot_d    = slot_nxt;
                                credito_d = weight_nxt;
                            end else begin
                                credito_d = credito_q - WW'(1);
                            end
                        end
                    end
                end
                default: state_d = S_INIT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_INIT;
            slot_q         <= '0;
            credito_q      <= '0;
            selector_q     <= '0;
            selector_enb_q <= 1'b0;
            urgente_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            slot_q         <= slot_d;
            credito_q      <= credito_d;
            selector_q     <= selector_d;
            selector_enb_q <= selector_enb_d;
            urgente_q      <= urgente_d;
        end
    end

    assign selector     = selector_q;
    assign selector_enb = selector_enb_q;
    assign urgente      = urgente_q;
    assign slot_idx     = slot_q;

endmodule

// File: tb/tb_round_robin_ponderado_gen.sv
// Directed bench for the weighted round-robin arbiter with hand-computed grant sequences.
module tb_round_robin_ponderado_gen;

    localparam int QQ = 4;
    localparam int BW = 3;
    localparam int WW = 6;
    localparam int TS = 8;
    localparam int SW = 2;
    localparam int TW = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              enb;
    logic              dest_ready;
    logic [TS*WW-1:0]  pesos;
    logic [TS*SW-1:0]  selecciones;
    logic [QQ-1:0]     buf_empty;
    logic [QQ*BW-1:0]  fifo_counter;
    logic [BW-1:0]     umbral_alto;
    logic              modo_urgente;
    logic [SW-1:0]     selector;
    logic              selector_enb;
    logic              urgente;
    logic [TW-1:0]     slot_idx;

    int n_chk  = 0;
    int n_pass = 0;

    int t2_enb[12]  = '{1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 1};
    int t2_sel[12]  = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 0, 0, 1};
    int t2_slot[12] = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 0, 1, 2};

    round_robin_ponderado_gen #(
        .QUEUE_QUANTITY (QQ),
        .BUF_WIDTH      (BW),
        .MAX_WEIGHT     (64),
        .TABLE_SIZE     (TS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enb          (enb),
        .dest_ready   (dest_ready),
        .pesos        (pesos),
        .selecciones  (selecciones),
        .buf_empty    (buf_empty),
        .fifo_counter (fifo_counter),
        .umbral_alto  (umbral_alto),
        .modo_urgente (modo_urgente),
        .selector     (selector),
        .selector_enb (selector_enb),
        .urgente      (urgente),
        .slot_idx     (slot_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Advance one edge, then compare outputs; e_sel < 0 skips the selector.
    task automatic step_chk(input string tag, input int e_enb, input int e_sel,
                            input int e_urg, input int e_slot);
        @(posedge clk);
        #1;
        chk({tag, ".enb"}, int'(selector_enb), e_enb);
        if (e_sel >= 0) chk({tag, ".sel"}, int'(selector), e_sel);
        chk({tag, ".urg"}, int'(urgente), e_urg);
        chk({tag, ".slot"}, int'(slot_idx), e_slot);
    endtask

    task automatic set_slot(input int s, input int q, input int w);
        pesos[s*WW +: WW]       = WW'(w);
        selecciones[s*SW +: SW] = SW'(q);
    endtask

    task automatic set_cnt(input int q, input int c);
        fifo_counter[q*BW +: BW] = BW'(c);
        buf_empty[q]             = (c == 0);
    endtask

    task automatic clear_cfg();
        pesos        = '0;
        selecciones  = '0;
        fifo_counter = '0;
        buf_empty    = '1;
    endtask

    // Pulse reset, then take the init edge (credit load, no grant).
    task automatic restart(input string tag);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        enb = 1'b1;
        dest_ready = 1'b1;
        step_chk({tag, ".init"}, 0, -1, 0, 0);
    endtask

    initial begin
        rst          = 1'b1;
        enb          = 1'b0;
        dest_ready   = 1'b1;
        modo_urgente = 1'b0;
        umbral_alto  = 3'd7;
        clear_cfg();

        // Reset state and first grants
        repeat (2) @(posedge clk);
        #1;
        chk("rst.enb", int'(selector_enb), 0);
        chk("rst.sel", int'(selector), 0);
        chk("rst.urg", int'(urgente), 0);
        chk("rst.slot", int'(slot_idx), 0);
        set_slot(0, 1, 3);
        for (int q = 0; q < QQ; q++) set_cnt(q, 5);
        rst = 1'b0;
        enb = 1'b1;
        step_chk("t1.init", 0, 0, 0, 0);
        step_chk("t1.grant", 1, 1, 0, 0);
        step_chk("t1.grant2", 1, 1, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("t1.arst.enb", int'(selector_enb), 0);
        chk("t1.arst.slot", int'(slot_idx), 0);
        chk("t1.arst.sel", int'(selector), 0);

        // Weighted sequence
        clear_cfg();
        set_slot(0, 0, 2);
        set_slot(1, 1, 1);
        for (int q = 0; q < QQ; q++) set_cnt(q, 5);
        restart("t2");
        for (int i = 0; i < 12; i++)
            step_chk($sformatf("t2.c%0d", i), t2_enb[i], t2_sel[i], 0, t2_slot[i]);

        // Empty forfeit
        clear_cfg();
        set_slot(0, 2, 4);
        set_slot(1, 3, 1);
        set_cnt(2, 2);
        set_cnt(3, 5);
        restart("t3");
        step_chk("t3.g1", 1, 2, 0, 0);
        step_chk("t3.g2", 1, 2, 0, 0);
        set_cnt(2, 0);
        step_chk("t3.forfeit", 0, 2, 0, 1);
        step_chk("t3.next", 1, 3, 0, 2);

        // Urgent override
        clear_cfg();
        set_slot(0, 0, 2);
        set_cnt(0, 5);
        set_cnt(1, 7);
        set_cnt(3, 6);
        modo_urgente = 1'b1;
        umbral_alto  = 3'd6;
        restart("t4");
        step_chk("t4.urg_low", 1, 1, 1, 0);
        set_cnt(1, 0);
        step_chk("t4.urg3", 1, 3, 1, 0);
        set_cnt(3, 5);
        step_chk("t4.resume1", 1, 0, 0, 0);
        step_chk("t4.resume2", 1, 0, 0, 1);
        modo_urgente = 1'b0;

        // Stale-status guard
        clear_cfg();
        set_slot(0, 1, 3);
        set_slot(1, 2, 1);
        set_cnt(1, 1);
        set_cnt(2, 5);
        restart("t5");
        step_chk("t5.grant", 1, 1, 0, 0);
        step_chk("t5.guard", 0, 1, 0, 0);
        set_cnt(1, 0);
        step_chk("t5.empty", 0, 1, 0, 1);
        step_chk("t5.next", 1, 2, 0, 2);

        // Freeze via dest_ready, then via enb
        clear_cfg();
        set_slot(0, 2, 3);
        set_slot(1, 1, 2);
        for (int q = 0; q < QQ; q++) set_cnt(q, 5);
        restart("t6");
        step_chk("t6.g1", 1, 2, 0, 0);
        dest_ready = 1'b0;
        for (int i = 0; i < 3; i++) step_chk($sformatf("t6.rdy_hold%0d", i), 0, 2, 0, 0);
        dest_ready = 1'b1;
        step_chk("t6.g2", 1, 2, 0, 0);
        step_chk("t6.g3", 1, 2, 0, 1);
        enb = 1'b0;
        for (int i = 0; i < 3; i++) step_chk($sformatf("t6.enb_hold%0d", i), 0, 2, 0, 1);
        enb = 1'b1;
        step_chk("t6.g4", 1, 1, 0, 1);
        step_chk("t6.g5", 1, 1, 0, 2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
